// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-time game controller.
package reaction_pkg;

  // Controller states; the ST_ prefix keeps ST_GAP clear of the GAP parameter.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DELAY   = 3'd1,
    ST_ARMED   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_GAP     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Result recorded for a miss or a false start.
  localparam logic [7:0] MISS_CODE = 8'hFF;

  // Feedback taps 8,6,5,4 (stage n is bit n-1): x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  // Default LFSR reset value; any nonzero value works.
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  // Smaller of two 8-bit results.
  function automatic logic [7:0] min8(input logic [7:0] a, input logic [7:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR used to randomise the pre-LED delay.
// A nonzero seed keeps it on the maximal-length cycle, so it never reaches zero.
module lfsr8
  import reaction_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] seed,
  output logic [7:0] q
);

  logic [7:0] q_q;
  logic [7:0] q_d;
  logic       feedback;

  assign feedback = ^(q_q & LFSR_TAPS);
  assign q_d      = {q_q[6:0], feedback};

  // Shift register: load the seed on reset, otherwise advance every cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop in
    // the design samples its inputs from the same pre-edge values.
    if (rst) begin
      q_q <= seed;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: random delay, LED window, result capture
// from an external timer, false-start and miss handling, and per-game
// last/best/average statistics.
module reaction_game_ctrl
  import reaction_pkg::*;
#(
  parameter int         ROUNDS    = 4,
  parameter int         DELAY_MIN = 16,
  parameter int         TIMEOUT   = 255,
  parameter int         GAP       = 4,
  parameter logic [7:0] SEED      = DEFAULT_SEED
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      button,
  input  logic [7:0]                time_in,
  output logic                      led_on,
  output logic                      busy,
  output logic [$clog2(ROUNDS)-1:0] round_idx,
  output logic [7:0]                last_time,
  output logic [7:0]                best_time,
  output logic [7:0]                avg_time,
  output logic                      foul,
  output logic                      done
);

  localparam int              RW          = $clog2(ROUNDS);
  localparam int              SW          = 8 + RW;
  localparam logic [8:0]      DELAY_BASE  = 9'(DELAY_MIN);
  localparam logic [8:0]      WINDOW_LAST = 9'(TIMEOUT - 1);
  localparam logic [8:0]      GAP_LOAD    = 9'(GAP - 1);
  localparam logic [RW-1:0]   LAST_ROUND  = RW'(ROUNDS - 1);

  // Elaboration-time parameter sanity checks.
  if ((ROUNDS < 2) || (ROUNDS > 8) || ((ROUNDS & (ROUNDS - 1)) != 0)) begin : g_bad_rounds
    $error("ROUNDS must be a power of two between 2 and 8");
  end
  if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_bad_timeout
    $error("TIMEOUT must be in 2..255");
  end
  if (GAP < 2) begin : g_bad_gap
    $error("GAP must be at least 2");
  end
  if (SEED == 8'h00) begin : g_bad_seed
    $error("SEED must be nonzero");
  end
  if ((DELAY_MIN < 0) || (DELAY_MIN > 256)) begin : g_bad_delay
    $error("DELAY_MIN must fit the 9-bit delay counter with the LFSR added");
  end

  state_e          state_q, state_d;
  logic [8:0]      cnt_q, cnt_d;        // delay countdown, window count-up, gap countdown
  logic [RW-1:0]   round_q, round_d;
  logic [7:0]      last_q, last_d;
  logic [7:0]      best_q, best_d;
  logic [7:0]      avg_q, avg_d;
  logic [SW-1:0]   sum_q, sum_d;        // wide enough for ROUNDS misses, cannot overflow
  logic            led_q, led_d;
  logic            foul_q, foul_d;
  logic            btn_prev_q;

  logic [7:0]      lfsr_q;
  logic [8:0]      delay_load;
  logic            btn_rise;
  logic            rec_valid;
  logic [7:0]      rec_val;
  logic            busy_c;
  logic            done_c;

  lfsr8 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .seed (SEED),
    .q    (lfsr_q)
  );

  assign delay_load = DELAY_BASE + {1'b0, lfsr_q};

  // A press is a fresh rising edge; a button already held does not count.
  assign btn_rise = button & ~btn_prev_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      round_q    <= '0;
      last_q     <= '0;
      best_q     <= MISS_CODE;
      avg_q      <= '0;
      sum_q      <= '0;
      led_q      <= 1'b0;
      foul_q     <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      round_q    <= round_d;
      last_q     <= last_d;
      best_q     <= best_d;
      avg_q      <= avg_d;
      sum_q      <= sum_d;
      led_q      <= led_d;
      foul_q     <= foul_d;
      btn_prev_q <= button;
    end
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    cnt_d     = cnt_q;
    round_d   = round_q;
    last_d    = last_q;
    best_d    = best_q;
    avg_d     = avg_q;
    sum_d     = sum_q;
    led_d     = led_q;
    foul_d    = 1'b0;
    rec_valid = 1'b0;
    rec_val   = MISS_CODE;
    busy_c    = 1'b0;
    done_c    = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        done_c = (state_q == ST_DONE);
        if (start) begin
          round_d = '0;
          sum_d   = '0;
          last_d  = '0;
          best_d  = MISS_CODE;
          cnt_d   = delay_load;
          state_d = ST_DELAY;
        end
      end

      ST_DELAY: begin
        busy_c = 1'b1;
        if (btn_rise) begin
          // False start: the LED stays dark for this round.
          foul_d    = 1'b1;
          rec_valid = 1'b1;
          cnt_d     = GAP_LOAD;
          state_d   = ST_GAP;
        end else if (cnt_q == '0) begin
          led_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_ARMED;
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end

      ST_ARMED: begin
        busy_c = 1'b1;
        // A press wins over a timeout landing on the same cycle.
        if (btn_rise) begin
          led_d   = 1'b0;
          state_d = ST_CAPTURE;
        end else if (cnt_q == WINDOW_LAST) begin
          led_d     = 1'b0;
          rec_valid = 1'b1;
          cnt_d     = GAP_LOAD;
          state_d   = ST_GAP;
        end else begin
          cnt_d = cnt_q + 9'd1;
        end
      end

      ST_CAPTURE: begin
        // The timer stopped when the LED dropped; its output is now stable.
        busy_c    = 1'b1;
        rec_valid = 1'b1;
        rec_val   = time_in;
        cnt_d     = GAP_LOAD;
        state_d   = ST_GAP;
      end

      ST_GAP: begin
        busy_c = 1'b1;
        if (cnt_q == '0) begin
          if (round_q == LAST_ROUND) begin
            avg_d   = 8'(sum_q >> RW);
            state_d = ST_DONE;
          end else begin
            round_d = round_q + RW'(1);
            cnt_d   = delay_load;
            state_d = ST_DELAY;
          end
        end else begin
          cnt_d = cnt_q - 9'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        led_d   = 1'b0;
      end
    endcase

    if (rec_valid) begin
      last_d = rec_val;
      sum_d  = sum_q + SW'(rec_val);
      best_d = min8(best_q, rec_val);
    end
  end

  assign led_on    = led_q;
  assign busy      = busy_c;
  assign done      = done_c;
  assign foul      = foul_q;
  assign round_idx = round_q;
  assign last_time = last_q;
  assign best_time = best_q;
  assign avg_time  = avg_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Bench for reaction_game_ctrl: two instances (long and short LED window),
// each fed by a small model of the external reaction timer.
module tb_reaction_game_ctrl;

  localparam int ROUND_BUDGET = 2000;
  localparam int SHORT_TO     = 8;

  typedef enum int {M_PRESS, M_FOUL, M_TIMEOUT, M_HOLD} mode_e;

  typedef struct {
    int         inst;
    mode_e      mode;
    int         n;          // press n cycles after LED rise
    logic [7:0] exp_last;
    int         exp_led;    // cycles the LED is seen high this round
    int         exp_foul;   // foul pulse cycles this round
  } round_t;

  typedef struct {
    int         inst;
    logic [7:0] exp_last;
    logic [7:0] exp_best;
    logic [7:0] exp_avg;
  } game_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_s  [2];
  logic       button_s [2];
  logic [7:0] tin_s    [2];
  logic       prev_led [2];
  logic       led_s    [2];
  logic       busy_s   [2];
  logic       foul_s   [2];
  logic       done_s   [2];
  logic [1:0] round_s  [2];
  logic [7:0] last_s   [2];
  logic [7:0] best_s   [2];
  logic [7:0] avg_s    [2];

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q [$];

  round_t     rounds [12];
  game_t      games  [3];

  always #5 clk = ~clk;

  reaction_game_ctrl #(.ROUNDS(4), .DELAY_MIN(4), .TIMEOUT(255), .GAP(4)) u_dut_long (
    .clk(clk), .rst(rst), .start(start_s[0]), .button(button_s[0]), .time_in(tin_s[0]),
    .led_on(led_s[0]), .busy(busy_s[0]), .round_idx(round_s[0]), .last_time(last_s[0]),
    .best_time(best_s[0]), .avg_time(avg_s[0]), .foul(foul_s[0]), .done(done_s[0])
  );

  reaction_game_ctrl #(.ROUNDS(4), .DELAY_MIN(4), .TIMEOUT(SHORT_TO), .GAP(4)) u_dut_short (
    .clk(clk), .rst(rst), .start(start_s[1]), .button(button_s[1]), .time_in(tin_s[1]),
    .led_on(led_s[1]), .busy(busy_s[1]), .round_idx(round_s[1]), .last_time(last_s[1]),
    .best_time(best_s[1]), .avg_time(avg_s[1]), .foul(foul_s[1]), .done(done_s[1])
  );

  // Timer model: restarts at 1 on the first lit cycle, counts while lit, holds when dark.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        tin_s[i]    <= 8'd0;
        prev_led[i] <= 1'b0;
      end else begin
        prev_led[i] <= led_s[i];
        if (led_s[i] && !prev_led[i]) tin_s[i] <= 8'd1;
        else if (led_s[i])            tin_s[i] <= tin_s[i] + 8'd1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_reset(input int i, input string tag);
    check({tag, "_led"},   32'(led_s[i]),   0);
    check({tag, "_busy"},  32'(busy_s[i]),  0);
    check({tag, "_done"},  32'(done_s[i]),  0);
    check({tag, "_foul"},  32'(foul_s[i]),  0);
    check({tag, "_round"}, 32'(round_s[i]), 0);
    check({tag, "_last"},  32'(last_s[i]),  0);
    check({tag, "_best"},  32'(best_s[i]),  32'hFF);
    check({tag, "_avg"},   32'(avg_s[i]),   0);
  endtask

  // Pulse start; returns on the negedge where the DUT sits in its first DELAY cycle.
  task automatic start_game(input int i);
    @(negedge clk); start_s[i] = 1'b1;
    @(negedge clk); start_s[i] = 1'b0;
  endtask

  // Plays one round and scores it when the DUT moves to the next round or to DONE.
  task automatic play_round(input round_t rv, input string tag);
    int         led_cnt, foul_cnt, press_cyc, i;
    bit         fin;
    logic [1:0] r0;
    logic [7:0] exp_last;
    i         = rv.inst;
    led_cnt   = 0;
    foul_cnt  = 0;
    press_cyc = -10;
    fin       = 1'b0;
    r0        = round_s[i];
    exp_q.push_back(rv.exp_last);
    for (int cyc = 0; cyc < ROUND_BUDGET && !fin; cyc++) begin
      @(negedge clk);
      if (led_s[i])  led_cnt++;
      if (foul_s[i]) foul_cnt++;
      if ((busy_s[i] && round_s[i] != r0) || done_s[i]) fin = 1'b1;
      if (cyc == press_cyc + 1) button_s[i] = 1'b0;
      if (!fin && ((rv.mode == M_PRESS && led_s[i] && led_cnt == rv.n) ||
                   (rv.mode == M_FOUL && cyc == 0))) begin
        button_s[i] = 1'b1;
        press_cyc   = cyc;
      end
    end
    if (rv.mode == M_HOLD) button_s[i] = 1'b0;
    check({tag, "_ended"}, 32'(fin), 1);
    exp_last = exp_q.pop_front();
    if (fin) check({tag, "_last"}, 32'(last_s[i]), 32'(exp_last));
    check({tag, "_led_cycles"}, 32'(led_cnt), 32'(rv.exp_led));
    check({tag, "_foul_pulses"}, 32'(foul_cnt), 32'(rv.exp_foul));
  endtask

  initial begin
    int   waited;
    // Game 0: normal presses. Game 1: false start in round 1. Game 2: short window.
    rounds[0]  = '{0, M_PRESS,   10, 8'd10,  10, 0};
    rounds[1]  = '{0, M_PRESS,   20, 8'd20,  20, 0};
    rounds[2]  = '{0, M_PRESS,   30, 8'd30,  30, 0};
    rounds[3]  = '{0, M_PRESS,   40, 8'd40,  40, 0};
    rounds[4]  = '{0, M_PRESS,   20, 8'd20,  20, 0};
    rounds[5]  = '{0, M_FOUL,     0, 8'hFF,   0, 1};
    rounds[6]  = '{0, M_PRESS,   20, 8'd20,  20, 0};
    rounds[7]  = '{0, M_PRESS,   20, 8'd20,  20, 0};
    rounds[8]  = '{1, M_HOLD,     0, 8'hFF, SHORT_TO, 0};
    rounds[9]  = '{1, M_TIMEOUT,  0, 8'hFF, SHORT_TO, 0};
    rounds[10] = '{1, M_PRESS, SHORT_TO, 8'd8, SHORT_TO, 0};
    rounds[11] = '{1, M_PRESS,    3, 8'd3,    3, 0};
    games[0]   = '{0, 8'd40, 8'd10, 8'd25};    // (10+20+30+40)/4
    games[1]   = '{0, 8'd20, 8'd20, 8'd78};    // (20+255+20+20)>>2
    games[2]   = '{1, 8'd3,  8'd3,  8'd130};   // (255+255+8+3)>>2

    for (int i = 0; i < 2; i++) begin
      start_s[i]  = 1'b0;
      button_s[i] = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset(0, "por0");
    check_reset(1, "por1");
    rst = 1'b0;

    for (int g = 0; g < 2; g++) begin
      int gi;
      gi = games[g].inst;
      if (rounds[g * 4].mode == M_HOLD) button_s[gi] = 1'b1;
      start_game(gi);
      check($sformatf("g%0d_start_busy", g),  32'(busy_s[gi]),  1);
      check($sformatf("g%0d_start_last", g),  32'(last_s[gi]),  0);
      check($sformatf("g%0d_start_best", g),  32'(best_s[gi]),  32'hFF);
      check($sformatf("g%0d_start_round", g), 32'(round_s[gi]), 0);
      for (int r = 0; r < 4; r++) play_round(rounds[g * 4 + r], $sformatf("g%0d_r%0d", g, r));
      check($sformatf("g%0d_done", g),  32'(done_s[gi]),  1);
      check($sformatf("g%0d_busy", g),  32'(busy_s[gi]),  0);
      check($sformatf("g%0d_round", g), 32'(round_s[gi]), 3);
      check($sformatf("g%0d_last", g),  32'(last_s[gi]),  32'(games[g].exp_last));
      check($sformatf("g%0d_best", g),  32'(best_s[gi]),  32'(games[g].exp_best));
      check($sformatf("g%0d_avg", g),   32'(avg_s[gi]),   32'(games[g].exp_avg));
    end

    // Mid-game start is ignored, then reset while the LED is lit.
    start_game(0);
    play_round('{0, M_PRESS, 5, 8'd5, 5, 0}, "rg_r0");
    start_game(0);
    check("midstart_round", 32'(round_s[0]), 1);
    check("midstart_last",  32'(last_s[0]),  5);
    check("midstart_busy",  32'(busy_s[0]),  1);
    waited = 0;
    while (!led_s[0] && waited < ROUND_BUDGET) begin
      @(negedge clk);
      waited++;
    end
    check("rg_led_lit", 32'(led_s[0]), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset(0, "armed_rst");
    rst = 1'b0;

    // Game 2 on the short-window instance, which the reset returned to IDLE.
    begin
      int gi;
      gi = games[2].inst;
      button_s[gi] = 1'b1;
      start_game(gi);
      check("g2_start_busy", 32'(busy_s[gi]), 1);
      for (int r = 0; r < 4; r++) play_round(rounds[8 + r], $sformatf("g2_r%0d", r));
      check("g2_done", 32'(done_s[gi]), 1);
      check("g2_busy", 32'(busy_s[gi]), 0);
      check("g2_last", 32'(last_s[gi]), 32'(games[2].exp_last));
      check("g2_best", 32'(best_s[gi]), 32'(games[2].exp_best));
      check("g2_avg",  32'(avg_s[gi]),  32'(games[2].exp_avg));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
REACTION_GAME_CTRL -- requirements
Module: reaction_game_ctrl

Interface
REQ-001 Parameter ROUNDS, default 4, rounds per game; power of two from 2 to 8.
REQ-002 Parameter DELAY_MIN, default 16, minimum random-delay cycles before the LED turns on.
REQ-003 Parameter TIMEOUT, default 255, maximum LED-on cycles; range 2..255.
REQ-004 Parameter GAP, default 4, LED-off cycles between rounds; minimum 2.
REQ-005 Parameter SEED, default 8'hA5, LFSR reset value; must be nonzero.
REQ-006 Ports are clk, rst, start, button, time_in, led_on, busy, round_idx, last_time, best_time, avg_time, foul, done; details in REQ-007..REQ-011.
REQ-007 Clock and reset: one clock; reset is synchronous and active-high. clk is an input, width 1. rst is an input, width 1.
REQ-008 start (input, 1): pulse that begins a game. button (input, 1): player button, already synchronous to clk.
REQ-009 time_in (input, 8): the timer's registered time_out. led_on (output, 1): drives the timer's led_on and the LED.
REQ-010 busy (output, 1): game in progress. round_idx (output, clog2(ROUNDS)): current round number. last_time (output, 8): result of the most recent round.
REQ-011 best_time (output, 8): minimum result of the game. avg_time (output, 8): mean result. foul (output, 1): one-cycle pulse on a false start. done (output, 1): level, game complete.

Function
REQ-012 The controller shall use one FSM with states IDLE, DELAY, ARMED, CAPTURE, GAP, DONE.
REQ-013 IDLE: start=1 shall clear round_idx, the result sum, last_time and done, set best_time=8'hFF, and enter DELAY.
REQ-014 DELAY: on entry, load delay count = DELAY_MIN + lfsr[7:0], 9-bit, and decrement each cycle; at zero, enter ARMED with led_on=1 on the next cycle.
REQ-015 ARMED: led_on=1 and the window counter increments from 0.
REQ-016 A button rising edge (button=1, registered prev=0) in ARMED shall clear led_on on that clock and enter CAPTURE.
REQ-017 CAPTURE (1 cycle): sample time_in as the round result.
REQ-018 Window counter reaching TIMEOUT with no edge shall clear led_on and record MISS=8'hFF; an edge in the same cycle as timeout counts as a press.
REQ-019 A button rising edge in DELAY is a false start: pulse foul for 1 cycle, record MISS, go to GAP, led_on stays 0.
REQ-020 A button held high across the DELAY-to-ARMED transition is not a press; a new rising edge is required.
REQ-021 Each recorded result shall update last_time and add to the sum; best_time = min(best_time, result).
REQ-022 The sum register is 8+log2(ROUNDS) bits and never overflows.
REQ-023 GAP: hold led_on=0 for GAP cycles so the timer re-arms; then round_idx+1 and go to DELAY, or go to DONE after round ROUNDS-1.
REQ-024 DONE: avg_time = sum >> log2(ROUNDS), registered on entry; done=1 and busy=0; start=1 begins a new game (REQ-013).
REQ-025 start shall be ignored in every state other than IDLE and DONE.
REQ-026 busy=1 in DELAY, ARMED, CAPTURE and GAP.
REQ-027 An 8-bit Fibonacci LFSR with taps 8,6,5,4 shall advance every cycle, including in IDLE, and never reach zero.

Reset
REQ-028 While rst=1 at a clk edge: state=IDLE, led_on=0, busy=0, foul=0, done=0, round_idx=0, last_time=0, best_time=8'hFF, avg_time=0, sum=0, lfsr=SEED.
REQ-029 Reset mid-round shall drop led_on on the first clock edge with rst=1; no partial result is recorded.

Structure
REQ-030 Package reaction_pkg shall hold the state enum, MISS_CODE=8'hFF, LFSR tap constant and default SEED.
REQ-031 The LFSR shall be sub-module lfsr8 (clk, rst, seed, q[7:0]); all other logic stays in reaction_game_ctrl.

Verification
REQ-032 Normal game: DELAY_MIN=4, 4 rounds, presses 10/20/30/40 cycles after led_on rises, bench timer model returns those values -> last_time=40, best_time=10, avg_time=25, done=1.
REQ-033 False start: press in round 1 DELAY -> foul pulse of 1 cycle, led_on never rises that round, last_time=8'hFF; remaining presses 20 -> best_time=20.
REQ-034 Timeout: TIMEOUT=8, no press -> led_on high exactly 8 cycles, last_time=8'hFF.
REQ-035 Edge coincident with timeout cycle -> treated as a press; last_time = time_in.
REQ-036 Button held from DELAY through led_on rise, never released -> timeout, last_time=8'hFF.
REQ-037 rst asserted in ARMED -> led_on=0 next edge; all outputs at reset values; start mid-game is ignored.
